// File: rtl/sub_bus_uart_loader_if.sv
// Sub-bus loader interface: UART byte stream in, RAM port out, frame status out.
//
// Byte handshake: a byte moves from the UART receiver into the loader on
// every rising bus_clock edge where i_rx_valid and o_rx_ready are both high.
// The receiver holds i_rx_data stable while i_rx_valid is high and the byte
// has not yet been taken; o_rx_ready never depends on i_rx_valid.
interface sub_bus_uart_loader_if;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        o_rx_ready;
  logic        o_bus_we;
  logic [15:0] o_bus_addr;
  logic [15:0] o_bus_data_write;
  logic [15:0] i_bus_data_read;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [2:0]  o_err_code;

  // Loader side
  modport master (
    input  i_rx_valid, i_rx_data, i_bus_data_read,
    output o_rx_ready, o_bus_we, o_bus_addr, o_bus_data_write,
           o_busy, o_done, o_error, o_err_code
  );

  // UART receiver / RAM / status consumer side
  modport slave (
    output i_rx_valid, i_rx_data, i_bus_data_read,
    input  o_rx_ready, o_bus_we, o_bus_addr, o_bus_data_write,
           o_busy, o_done, o_error, o_err_code
  );
endinterface

// File: rtl/sub_bus_uart_loader.sv
// Program loader: takes a framed byte stream from the UART, writes each
// 16-bit word into main RAM, reads it back to verify, and checks a frame
// checksum. o_busy holds the RAM port for the loader while a frame runs.
module sub_bus_uart_loader #(
  parameter int         ADDRESS_LIMIT  = 48896,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] SYNC_BYTE      = 8'hB5
) (
  input  logic                    bus_clock,
  input  logic                    reset,
  sub_bus_uart_loader_if.master   bus,
  output logic [3:0]              dbg_state
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    H_AH  = 4'd1,
    H_AL  = 4'd2,
    H_CH  = 4'd3,
    H_CL  = 4'd4,
    D_HI  = 4'd5,
    D_LO  = 4'd6,
    WR    = 4'd7,
    RD    = 4'd8,
    CMP   = 4'd9,
    C_HI  = 4'd10,
    C_LO  = 4'd11,
    FIN   = 4'd12,
    ABORT = 4'd13
  } state_t;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_RANGE    = 3'd1;
  localparam logic [2:0] ERR_VERIFY   = 3'd2;
  localparam logic [2:0] ERR_CHECKSUM = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]     LIMIT17  = 17'(ADDRESS_LIMIT);

  state_t            state_q;
  logic              live_q;      // low during reset so o_rx_ready resets to 0
  logic [7:0]        hi_q;        // high byte of whichever field is arriving
  logic [15:0]       addr_q;      // next RAM word address
  logic [15:0]       cnt_q;       // words still to load
  logic [15:0]       word_q;      // word being written / verified
  logic [15:0]       sum_q;       // running checksum of verified words
  logic [TMO_W-1:0]  tmo_q;       // cycles waited for the next byte
  logic              we_q;
  logic [15:0]       bus_addr_q;
  logic [15:0]       bus_wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [2:0]        err_code_q;

  logic              byte_state;
  logic              xfer;
  logic [15:0]       rx_word;
  logic [16:0]       range_sum;
  logic              range_bad;

  // Decode of byte-accepting states, transfer strobe and header arithmetic
  always_comb begin
    byte_state = 1'b0;
    case (state_q)
      IDLE, H_AH, H_AL, H_CH, H_CL, D_HI, D_LO, C_HI, C_LO: byte_state = 1'b1;
      default:                                              byte_state = 1'b0;
    endcase
    xfer      = bus.i_rx_valid & live_q & byte_state;
    rx_word   = {hi_q, bus.i_rx_data};
    range_sum = {1'b0, addr_q} + {1'b0, rx_word};
    range_bad = range_sum > LIMIT17;
  end

  assign bus.o_rx_ready       = live_q & byte_state;
  assign bus.o_bus_we         = we_q;
  assign bus.o_bus_addr       = bus_addr_q;
  assign bus.o_bus_data_write = bus_wdata_q;
  assign bus.o_busy           = busy_q;
  assign bus.o_done           = done_q;
  assign bus.o_error          = error_q;
  assign bus.o_err_code       = err_code_q;
  assign dbg_state            = state_q;

  // Loader FSM with registered bus and status outputs
  always_ff @(posedge bus_clock) begin
    if (reset) begin
      state_q     <= IDLE;
      live_q      <= 1'b0;
      hi_q        <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
      we_q        <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      live_q  <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (xfer && bus.i_rx_data == SYNC_BYTE) begin
            state_q    <= H_AH;
            err_code_q <= ERR_NONE;
            busy_q     <= 1'b1;
            tmo_q      <= '0;
          end
        end

        H_AH, H_AL, H_CH, H_CL, D_HI, D_LO, C_HI, C_LO: begin
          if (xfer) begin
            tmo_q <= '0;
            case (state_q)
              H_AH: begin
                hi_q    <= bus.i_rx_data;
                state_q <= H_AL;
              end
              H_AL: begin
                addr_q  <= rx_word;
                state_q <= H_CH;
              end
              H_CH: begin
                hi_q    <= bus.i_rx_data;
                state_q <= H_CL;
              end
              H_CL: begin
                if (range_bad) begin
                  state_q     <= ABORT;
                  err_code_q  <= ERR_RANGE;
                  error_q     <= 1'b1;
                  busy_q      <= 1'b0;
                  bus_addr_q  <= '0;
                  bus_wdata_q <= '0;
                end else begin
                  cnt_q   <= rx_word;
                  sum_q   <= '0;
                  state_q <= (rx_word == 16'd0) ? C_HI : D_HI;
                end
              end
              D_HI: begin
                hi_q    <= bus.i_rx_data;
                state_q <= D_LO;
              end
              D_LO: begin
                word_q      <= rx_word;
                we_q        <= 1'b1;
                bus_addr_q  <= addr_q;
                bus_wdata_q <= rx_word;
                state_q     <= WR;
              end
              C_HI: begin
                hi_q    <= bus.i_rx_data;
                state_q <= C_LO;
              end
              default: begin  // C_LO
                if (rx_word == sum_q) begin
                  state_q <= FIN;
                  done_q  <= 1'b1;
                end else begin
                  state_q    <= ABORT;
                  err_code_q <= ERR_CHECKSUM;
                  error_q    <= 1'b1;
                end
                busy_q      <= 1'b0;
                bus_addr_q  <= '0;
                bus_wdata_q <= '0;
              end
            endcase
          end else if (tmo_q == TMO_LAST) begin
            state_q     <= ABORT;
            err_code_q  <= ERR_TIMEOUT;
            error_q     <= 1'b1;
            busy_q      <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        WR: begin
          we_q    <= 1'b0;
          state_q <= RD;
        end

        RD: begin
          state_q <= CMP;
        end

        CMP: begin
          if (bus.i_bus_data_read != word_q) begin
            state_q     <= ABORT;
            err_code_q  <= ERR_VERIFY;
            error_q     <= 1'b1;
            busy_q      <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
          end else begin
            sum_q   <= sum_q + word_q;
            addr_q  <= addr_q + 16'd1;
            cnt_q   <= cnt_q - 16'd1;
            tmo_q   <= '0;
            state_q <= (cnt_q == 16'd1) ? C_HI : D_HI;
          end
        end

        default: begin  // FIN, ABORT: status pulse already presented
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
